// File: rtl/aes_ks_pkg.sv
// =============================================================================
// Module   : aes_ks_pkg
// Brief    : Shared AES key-schedule types and helpers (forward and inverse).
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

package aes_ks_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES_WORD_W    = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        rc = 8'h00;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_ks_subword.sv
// =============================================================================
// Module   : aes_ks_subword
// Brief    : AES SubWord - four forward S-boxes across a 32-bit word.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module aes_ks_subword
    import aes_ks_pkg::*;
(
    input  logic [AES_WORD_W-1:0] in_word,
    output logic [AES_WORD_W-1:0] out_word
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (in_word[8*i +: 8]),
            .out_byte (out_word[8*i +: 8])
        );
    end

endmodule

`default_nettype wire

// File: rtl/aes_sbox.sv
// =============================================================================
// Module   : aes_sbox
// Brief    : AES forward S-box, single byte, purely combinational lookup.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0x00 sits in the top byte of the table.
    localparam logic [2047:0] C_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [10:0] C_TOP_BIT = 11'd2047;

    assign out_byte = C_SBOX_TABLE[C_TOP_BIT - {in_byte, 3'b000} -: 8];

endmodule

`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
// =============================================================================
// Module   : aes_inv_key_sched
// Brief    : Iterative AES-128 inverse key schedule; emits round keys 10..0.
//            Optional per-byte parity output under AES_INV_KS_PARITY_EN.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module aes_inv_key_sched
    import aes_ks_pkg::*;
#(
    parameter int ROUNDS  = AES128_ROUNDS,
    parameter int ROUND_W = $clog2(ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       key_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_key,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_last
`ifdef AES_INV_KS_PARITY_EN
    ,
    output logic [15:0]        out_par
`endif
);

    if (ROUNDS != 10) begin : g_rounds_check
        $error("aes_inv_key_sched supports only ROUNDS == 10");
    end

    ks_state_e                 r_state, w_state_next;
    logic      [127:0]         r_key, w_key_next;
    logic      [ROUND_W-1:0]   r_round, w_round_next;

    logic [AES_WORD_W-1:0] w_w0, w_w1, w_w2, w_w3;
    logic [AES_WORD_W-1:0] w_p0, w_p1, w_p2, w_p3;
    logic [AES_WORD_W-1:0] w_sub;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;

    // Undo the forward word chaining, then regenerate word 0 from recovered word 3.
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    aes_ks_subword u_subword (
        .in_word  (rot_word(w_p3)),
        .out_word (w_sub)
    );

    assign w_p0 = w_w0 ^ w_sub ^ {rcon(r_round), 24'h000000};

    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_round_next = r_round;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_key_next   = key_last;
                    w_round_next = ROUND_W'(ROUNDS);
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (r_round != '0) begin
                        w_key_next   = {w_p0, w_p1, w_p2, w_p3};
                        w_round_next = r_round - 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_round <= w_round_next;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == RUN);
    assign out_key   = r_key;
    assign out_round = r_round;
    assign out_last  = (r_state == RUN) && (r_round == '0);

`ifdef AES_INV_KS_PARITY_EN
    logic [15:0] r_par, w_par_next;

    for (genvar i = 0; i < 16; i++) begin : g_par
        assign w_par_next[i] = ^w_key_next[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= '0;
        end else begin
            r_par <= w_par_next;
        end
    end

    assign out_par = r_par;
`endif

endmodule

`default_nettype wire
